// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: shared widths, divider state encoding and decode bundle layout for the execute stage
// Macro ES_FWD_RESULT_EN widens the forward/block bus to carry the ES result.
package exe_stage_pkg;
  localparam int DS_TO_ES_BUS_WD = 139;
  localparam int ES_TO_MS_BUS_WD = 71;
`ifdef ES_FWD_RESULT_EN
  localparam int ES_FWD_BLK_BUS_WD = 40;
`else
  localparam int ES_FWD_BLK_BUS_WD = 7;
`endif
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;
  typedef struct packed {
    logic        div_en;
    logic        div_signed;
    logic        div_rem;
    logic [11:0] alu_op;
    logic        load_op;
    logic        src1_is_sa;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        src2_is_8;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [15:0] imm;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic [31:0] pc;
  } ds_to_es_t;
endpackage

// File: rtl/alu.sv
// alu: MIPS integer ALU, one-hot alu_op {lui,sra,srl,sll,xor,or,nor,and,sltu,slt,sub,add}
// Ports: alu_op (12b one-hot), alu_src1/alu_src2 operands, alu_result.
module alu (
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);
  logic        sub;
  logic [31:0] b;
  logic [32:0] sum;
  logic        slt, sltu;
  assign sub  = alu_op[1] | alu_op[2] | alu_op[3];
  assign b    = sub ? ~alu_src2 : alu_src2;
  assign sum  = {1'b0, alu_src1} + {1'b0, b} + 33'(sub);
  // signed compare from sign bits and difference; unsigned from the borrow
  assign slt  = (alu_src1[31] & ~alu_src2[31]) | (~(alu_src1[31] ^ alu_src2[31]) & sum[31]);
  assign sltu = ~sum[32];
  assign alu_result = ({32{alu_op[0] | alu_op[1]}} & sum[31:0])
                    | ({32{alu_op[2]}}  & {31'b0, slt})
                    | ({32{alu_op[3]}}  & {31'b0, sltu})
                    | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
                    | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                    | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
                    | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                    | ({32{alu_op[8]}}  & (alu_src2 << alu_src1[4:0]))
                    | ({32{alu_op[9]}}  & (alu_src2 >> alu_src1[4:0]))
                    | ({32{alu_op[10]}} & 32'($signed(alu_src2) >>> alu_src1[4:0]))
                    | ({32{alu_op[11]}} & {alu_src2[15:0], 16'b0});
endmodule

// File: rtl/exe_stage_div_iter.sv
// div_iter: 32-step restoring divider, IDLE -> BUSY -> DONE -> IDLE, with sign fix-up
// Ports: start (launch from IDLE), ack (leave DONE), signed_op, dividend/divisor,
//        busy/done status, quotient/remainder (stable while DONE).
module div_iter
  import exe_stage_pkg::*;
#(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             ack,
  input  logic             signed_op,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder
);
  localparam int CW = $clog2(DIV_W);
  div_state_e       state;
  logic [CW-1:0]    cnt;
  logic [DIV_W-1:0] quo, rem, dvs;
  logic             dvd_neg, q_neg, by_zero;
  logic [DIV_W:0]   shifted;
  logic [DIV_W+1:0] diff;
  logic             dvd_sgn, dvs_sgn;
  assign dvd_sgn = signed_op & dividend[DIV_W-1];
  assign dvs_sgn = signed_op & divisor[DIV_W-1];
  // quo starts as |dividend| and shifts out its MSB each step while quotient bits shift in
  assign shifted = {rem, quo[DIV_W-1]};
  assign diff    = {1'b0, shifted} - {2'b0, dvs};
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= DIV_IDLE;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      dvd_neg <= 1'b0;
      q_neg   <= 1'b0;
      by_zero <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          state   <= DIV_BUSY;
          cnt     <= '0;
          rem     <= '0;
          quo     <= dvd_sgn ? -dividend : dividend;
          dvs     <= dvs_sgn ? -divisor : divisor;
          dvd_neg <= dvd_sgn;
          q_neg   <= dvd_sgn ^ dvs_sgn;
          by_zero <= divisor == '0;
        end
        DIV_BUSY: begin
          quo <= {quo[DIV_W-2:0], ~diff[DIV_W+1]};
          rem <= diff[DIV_W+1] ? shifted[DIV_W-1:0] : diff[DIV_W-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DIV_W - 1)) state <= DIV_DONE;
        end
        DIV_DONE: if (ack) state <= DIV_IDLE;
        default: state <= DIV_IDLE;
      endcase
    end
  end
  assign busy = state == DIV_BUSY;
  assign done = state == DIV_DONE;
  // divide-by-zero leaves rem = |dividend|, so the sign fix restores the raw dividend
  assign quotient  = by_zero ? '1 : q_neg ? -quo : quo;
  assign remainder = dvd_neg ? -rem : rem;
endmodule

// File: rtl/exe_stage.sv
// exe_stage: MIPS execute stage - ALU, iterative DIV/DIVU, data-SRAM request, ES->MS handoff
// Ports: clk, resetn (async, low); ds_to_es_valid/ds_to_es_bus in, es_allowin out;
//        es_to_ms_valid/es_to_ms_bus out, ms_allowin in; data_sram_* request;
//        es_fwd_blk_bus to decode (40 bits with result when ES_FWD_RESULT_EN, else 7).
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DIV_W = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         ms_allowin,
  output logic                         es_allowin,
  input  logic                         ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0]   ds_to_es_bus,
  output logic                         es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
  output logic                         data_sram_en,
  output logic [3:0]                   data_sram_wen,
  output logic [31:0]                  data_sram_addr,
  output logic [31:0]                  data_sram_wdata,
  output logic [ES_FWD_BLK_BUS_WD-1:0] es_fwd_blk_bus
);
  logic             es_valid, es_ready_go;
  ds_to_es_t        es;
  logic [31:0]      src1, src2, alu_result, es_result;
  logic [DIV_W-1:0] div_q, div_r;
  logic             div_busy, div_done;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) es_valid <= 1'b0;
    else if (es_allowin) es_valid <= ds_to_es_valid;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) es <= '0;
    else if (ds_to_es_valid && es_allowin) es <= ds_to_es_bus;
  end
  assign es_ready_go    = !es.div_en || div_done;
  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;
  assign src1 = es.src1_is_sa ? {27'b0, es.imm[10:6]} : es.src1_is_pc ? es.pc : es.rs_value;
  assign src2 = es.src2_is_imm ? {{16{es.imm[15]}}, es.imm} : es.src2_is_8 ? 32'd8 : es.rt_value;
  alu u_alu (
    .alu_op    (es.alu_op),
    .alu_src1  (src1),
    .alu_src2  (src2),
    .alu_result(alu_result)
  );
  // start only from IDLE; ack on the handoff edge returns the divider to IDLE
  div_iter #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start    (es_valid && es.div_en && !div_busy && !div_done),
    .ack      (es_valid && div_done && ms_allowin),
    .signed_op(es.div_signed),
    .dividend (es.rs_value),
    .divisor  (es.rt_value),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q),
    .remainder(div_r)
  );
  assign es_result    = es.div_en ? (es.div_rem ? div_r : div_q) : alu_result;
  assign es_to_ms_bus = {es.load_op, es.gr_we, es.dest, es_result, es.pc};
  // request only on the handoff cycle so rdata lines up with the instruction in MS
  assign data_sram_en    = es_valid && (es.load_op || es.mem_we) && ms_allowin;
  assign data_sram_wen   = {4{es_valid && es.mem_we && ms_allowin}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = es.rt_value;
`ifdef ES_FWD_RESULT_EN
  logic es_fwd_valid;
  assign es_fwd_valid   = es_valid && es.gr_we && !es.load_op && es_ready_go;
  assign es_fwd_blk_bus = {es_fwd_valid, es_valid && es.load_op, es_valid && es.gr_we, es.dest, es_result};
`else
  assign es_fwd_blk_bus = {es_valid && es.load_op, es_valid && es.gr_we, es.dest};
`endif
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage in-order MIPS pipeline; sits between the decode stage and the memory stage.
- Latches the decode bundle and computes the ALU result through the existing `alu` module.
- Runs an iterative 32-step divider for DIV/DIVU. Issues the data-SRAM request for loads and stores.
- Emits the ES_TO_MS bundle and a hazard/forward bus back to decode.

Parameters:
- DIV_W, 32, operand/result width of the divider; must equal 32 in this CPU.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- ms_allowin  in  1  memory stage can accept
- es_allowin  out  1  execute stage can accept
- ds_to_es_valid  in  1  decode bundle valid
- ds_to_es_bus  in  `DS_TO_ES_BUS_WD (139)  {div_en, div_signed, div_rem, alu_op[11:0], load_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8, gr_we, mem_we, dest[4:0], imm[15:0], rs_value, rt_value, pc}
- es_to_ms_valid  out  1  bundle valid to memory stage
- es_to_ms_bus  out  `ES_TO_MS_BUS_WD (71)  {res_from_mem, gr_we, dest[4:0], result[31:0], pc[31:0]}
- data_sram_en  out  1  SRAM access enable
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  store data
- es_fwd_blk_bus  out  `ES_FWD_BLK_BUS_WD (7)  {es_is_load, es_rf_wen, es_rf_dest[4:0]}

Behaviour:
- Reset (resetn low, async):
  - es_valid=0; divider state IDLE; step counter=0.
  - All outputs are derived from es_valid, so es_to_ms_valid=0, data_sram_en=0, data_sram_wen=0, and es_fwd_blk_bus rf_wen=0.
  - Reset mid-division abandons the operation. No residual state survives.
- Handshake:
  - es_allowin = !es_valid || (es_ready_go && ms_allowin).
  - es_valid loads ds_to_es_valid when es_allowin.
  - The bundle register loads when ds_to_es_valid && es_allowin.
  - es_to_ms_valid = es_valid && es_ready_go.
  - es_ready_go = !div_en || div_state==DONE.
- Operands:
  - src1 = src1_is_sa ? {27'b0, imm[10:6]} : src1_is_pc ? pc : rs_value.
  - src2 = src2_is_imm ? sign-extended imm : src2_is_8 ? 32'd8 : rt_value.
- SRAM request:
  - data_sram_en = es_valid && (load_op||mem_we) && ms_allowin. It is asserted exactly in the handoff cycle, so rdata arrives while the instruction is in MS.
  - data_sram_wen = {4{es_valid && mem_we && ms_allowin}}.
  - data_sram_addr = alu_result; data_sram_wdata = rt_value.
- Divider FSM: IDLE -> BUSY -> DONE -> IDLE.
  - IDLE->BUSY at the edge ending the first cycle with es_valid && div_en. That edge latches |rs|, |rt| (abs only if div_signed) and both sign bits; counter=0.
  - BUSY: one restoring step per cycle. counter+1; after the step with counter==31, go to DONE.
  - Latency: entry in cycle N gives es_ready_go=1 in cycle N+33.
  - DONE holds while !ms_allowin (stall) and returns to IDLE on handoff.
  - A new div instruction entering on that same edge starts from IDLE on the next edge. There are no back-to-back shortcuts.
- Divider arithmetic:
  - Signed quotient is negated iff the operand signs differ. Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0.
  - Division by zero (either signedness) gives quotient 0xFFFFFFFF and remainder equal to the raw dividend.
- Result: result = div_en ? (div_rem ? remainder : quotient) : alu_result.
- ES_TO_MS bundle: res_from_mem=load_op.
- es_fwd_blk_bus: {es_valid && load_op, es_valid && gr_we, dest}. Decode stalls on a load match.

Optional Feature:
- Macro: ES_FWD_RESULT_EN.
- Defined:
  - `ES_FWD_BLK_BUS_WD = 40, bus = {es_fwd_valid, es_is_load, es_rf_wen, es_rf_dest, es_result}.
  - es_fwd_valid = es_valid && gr_we && !load_op && es_ready_go.
  - Lets decode forward a completed non-load result instead of stalling.
- Undefined: the 7-bit bus as above; decode stalls on any dest match.

Decomposition:
- mycpu.h gets: `DS_TO_ES_BUS_WD, `ES_TO_MS_BUS_WD, `ES_FWD_BLK_BUS_WD (both variants), and divider state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
- One new sub-module: div_iter (the FSM, counter, operand/partial-remainder registers and sign fix), with start/busy/done/quotient/remainder ports.
- `alu` is instantiated unchanged.

Test Plan:
- ADDU rs=5, rt=7, ms_allowin=1 -> es_to_ms_valid the cycle after entry, result=12, data_sram_en=0.
- SW, base 0x1000, imm 4, rt=0xDEADBEEF, ms_allowin=1 -> data_sram_en=1, wen=4'hF, addr=0x1004, wdata=0xDEADBEEF in the same cycle as es_to_ms_valid.
- DIVU 100/7, quotient select -> es_ready_go=0 for 33 cycles, then result=14. Repeat with rem select -> result=2.
- DIV signed 0x80000000 by 0xFFFFFFFF -> quotient 0x80000000. DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIVU 5/0 -> quotient 0xFFFFFFFF, remainder 5.
- DIV done with ms_allowin=0 for 4 cycles -> state stays DONE, result stable, es_allowin=0. Handoff on ms_allowin=1 with a following DIV entering -> second result after another 33 cycles.
- resetn pulsed low at BUSY step 10 -> es_valid=0 immediately, state IDLE. A fresh DIVU after release completes correctly in 33 cycles.
